// File: rtl/demux_stream_nto1_pkg.sv
// Shared types and constants for the N-way stream demux.
package demux_pkg;

  // Width of the saturating dropped-word counter.
  localparam int DROP_CNT_W = 8;

  // Routing mode of the word currently presented at the input.
  typedef enum logic {
    MODE_UNI   = 1'b0,
    MODE_BCAST = 1'b1
  } mode_e;

  // Select field width for n channels; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_stream_nto1_if.sv
// Bundle of the producer stream, the per-channel consumer streams and the
// drop status of the N-way stream demux.
interface demux_stream_nto1_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = sel_w(N_OUT)
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic                    err_sel;
  logic [DROP_CNT_W-1:0]   drop_cnt;

  // Environment side: producer and consumers.
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err_sel, drop_cnt
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err_sel, drop_cnt
  );

endinterface

// File: rtl/demux_stream_nto1_out_slot.sv
// One-entry output register of a single demux channel. The slot accepts a new
// word whenever it is empty or its current word leaves in the same cycle.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  logic              valid_p1;
  logic [DATA_W-1:0] data_p1;

  // Load wins over drain so back-to-back words flow without a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_p1 <= 1'b0;
      data_p1  <= '0;
    end else if (load) begin
      valid_p1 <= 1'b1;
      data_p1  <= load_data;
    end else if (ready) begin
      valid_p1 <= 1'b0;
    end
  end

  assign valid = valid_p1;
  assign data  = data_p1;
  assign free  = !valid_p1 || ready;

endmodule

// File: rtl/demux_stream_nto1.sv
// Registered 1-to-N stream demux: routes each accepted word to the channel
// named by in_sel, or to every channel on broadcast. Words with an
// out-of-range select are consumed, flagged and counted.
module demux_stream_nto1
  import demux_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  N_OUT  = 4,
  localparam int SEL_W  = sel_w(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_stream_nto1_if.slave bus
);

  localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

  // Saturating increment for the dropped-word counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  mode_e                   mode_p0;
  logic                    sel_ok_p0;
  logic                    sel_free_p0;
  logic                    in_ready_p0;
  logic                    drop_p0;
  logic [N_OUT-1:0]        free_p0;
  logic [N_OUT-1:0]        load_p0;
  logic [N_OUT-1:0]        valid_p1;
  logic [N_OUT*DATA_W-1:0] data_p1;
  logic                    err_sel_p1;
  logic [DROP_CNT_W-1:0]   drop_cnt_p1;

  assign mode_p0   = bus.in_bcast ? MODE_BCAST : MODE_UNI;
  assign sel_ok_p0 = ({1'b0, bus.in_sel} < N_OUT_W);

  // Free flag of the selected channel; zero when the select is out of range.
  always_comb begin
    sel_free_p0 = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.in_sel == SEL_W'(k)) sel_free_p0 = free_p0[k];
    end
  end

  // Acceptance and per-slot load decode; in_ready never looks at in_valid.
  always_comb begin
    in_ready_p0 = 1'b0;
    load_p0     = '0;
    drop_p0     = 1'b0;
    if (rst_n) begin
      unique case (mode_p0)
        MODE_BCAST: begin
          // All-or-nothing: wait until every slot can take the word.
          in_ready_p0 = &free_p0;
          if (bus.in_valid && in_ready_p0) load_p0 = '1;
        end
        MODE_UNI: begin
          if (sel_ok_p0) begin
            in_ready_p0 = sel_free_p0;
            for (int k = 0; k < N_OUT; k++) begin
              load_p0[k] = bus.in_valid && sel_free_p0 && (bus.in_sel == SEL_W'(k));
            end
          end else begin
            in_ready_p0 = 1'b1;
            drop_p0     = bus.in_valid;
          end
        end
        default: begin
          in_ready_p0 = 1'b0;
        end
      endcase
    end
  end

  // ---- stage boundary p0 -> p1: output slots ----
  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_out_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_p0[k]),
      .load_data (bus.in_data),
      .ready     (bus.out_ready[k]),
      .valid     (valid_p1[k]),
      .data      (data_p1[k*DATA_W +: DATA_W]),
      .free      (free_p0[k])
    );
  end

  // Error pulse and saturating count of words dropped for a bad select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel_p1  <= 1'b0;
      drop_cnt_p1 <= '0;
    end else begin
      err_sel_p1 <= drop_p0;
      if (drop_p0) drop_cnt_p1 <= sat_inc(drop_cnt_p1);
    end
  end

  assign bus.in_ready  = in_ready_p0;
  assign bus.out_valid = valid_p1;
  assign bus.out_data  = data_p1;
  assign bus.err_sel   = err_sel_p1;
  assign bus.drop_cnt  = drop_cnt_p1;

`ifndef SYNTHESIS
  // The producer must not change a word it is still offering.
  property p_stable_when_stalled;
    @(posedge clk) disable iff (!rst_n)
      (bus.in_valid && !bus.in_ready) |=> $stable({bus.in_data, bus.in_sel, bus.in_bcast});
  endproperty
  a_stable_when_stalled: assert property (p_stable_when_stalled)
    else $error("producer changed a stalled word");
`endif

endmodule
